// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle RV64M multiply/divide sequencer: shift-add multiplier and restoring divider, one bit per cycle.
// Optional MDU_FAST_MUL_EN replaces the iterative multiply with a single-cycle combinational product.
module mdu_seq_ctrl #(
    parameter int XLEN = 64,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OPW-1:0]  req_op,
    input  logic [XLEN-1:0] req_op1,
    input  logic [XLEN-1:0] req_op2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t state, state_next;

    logic [OPW-1:0]    op_q;
    logic              mul_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic [CW-1:0]     counter;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   opb;

    logic d_mul, d_div, d_w, d_sa, d_sb, d_rem, d_rsv;
    logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_neg, fast_data, fix_data;
    logic neg_a, neg_b, div0, ovf, fast_div, accept;
    logic [CW-1:0] n_iter;
    logic [2*XLEN-1:0] mul_sum, prod_fix;
    logic [XLEN:0] rem_sh, diff;
    logic [XLEN-1:0] quo_fix, rem_fix;
`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    assign req_ready  = (state == IDLE) && !rst && !flush;
    assign accept     = req_valid && req_ready;
    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);

    always_comb begin
        d_mul = 1'b0;
        d_div = 1'b0;
        d_w   = 1'b0;
        d_sa  = 1'b0;
        d_sb  = 1'b0;
        d_rem = 1'b0;
        d_rsv = 1'b0;
        case (req_op)
            OPW'(0):  d_mul = 1'b1;
            OPW'(1):  begin d_mul = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
            OPW'(2):  begin d_mul = 1'b1; d_sa = 1'b1; end
            OPW'(3):  d_mul = 1'b1;
            OPW'(4):  begin d_mul = 1'b1; d_w = 1'b1; end
            OPW'(5):  begin d_div = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
            OPW'(6):  d_div = 1'b1;
            OPW'(7):  begin d_div = 1'b1; d_rem = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
            OPW'(8):  begin d_div = 1'b1; d_rem = 1'b1; end
            OPW'(9):  begin d_div = 1'b1; d_w = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
            OPW'(10): begin d_div = 1'b1; d_w = 1'b1; end
            OPW'(11): begin d_div = 1'b1; d_w = 1'b1; d_rem = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
            OPW'(12): begin d_div = 1'b1; d_w = 1'b1; d_rem = 1'b1; end
            default:  d_rsv = 1'b1;
        endcase
    end

    // Operands become magnitudes; the result signs are reapplied in FIXUP.
    always_comb begin
        a_ext = req_op1;
        b_ext = req_op2;
        if (d_w) begin
            a_ext = d_sa ? sext32(req_op1[31:0]) : {{(XLEN-32){1'b0}}, req_op1[31:0]};
            b_ext = d_sb ? sext32(req_op2[31:0]) : {{(XLEN-32){1'b0}}, req_op2[31:0]};
        end
        neg_a   = d_sa && a_ext[XLEN-1];
        neg_b   = d_sb && b_ext[XLEN-1];
        abs_a   = neg_a ? -a_ext : a_ext;
        abs_b   = neg_b ? -b_ext : b_ext;
        min_neg = d_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div0    = d_div && (b_ext == '0);
        ovf     = d_div && d_sa && (a_ext == min_neg) && (b_ext == '1);
        n_iter  = d_w ? CW'(32) : CW'(XLEN);
    end

    assign fast_div = div0 || ovf;

    always_comb begin
        fast_data = '0;
        if (!d_rsv) begin
            if (div0)
                fast_data = d_rem ? (d_w ? sext32(req_op1[31:0]) : req_op1) : '1;
            else if (ovf)
                fast_data = d_rem ? '0 : a_ext;
        end
    end

`ifdef MDU_FAST_MUL_EN
    assign fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`endif

    assign mul_sum = acc + sh;
    assign rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign diff    = rem_sh - {1'b0, opb};

    always_comb begin
        prod_fix = neg_res_q ? -acc : acc;
        quo_fix  = neg_res_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            OPW'(0):                    fix_data = prod_fix[XLEN-1:0];
            OPW'(1), OPW'(2), OPW'(3):  fix_data = prod_fix[2*XLEN-1:XLEN];
            OPW'(4):                    fix_data = sext32(prod_fix[31:0]);
            OPW'(5), OPW'(6):           fix_data = quo_fix;
            OPW'(7), OPW'(8):           fix_data = rem_fix;
            OPW'(9), OPW'(10):          fix_data = sext32(quo_fix[31:0]);
            OPW'(11), OPW'(12):         fix_data = sext32(rem_fix[31:0]);
            default:                    fix_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (d_rsv || fast_div)
                        state_next = DONE;
`ifdef MDU_FAST_MUL_EN
                    else if (d_mul)
                        state_next = FIXUP;
`endif
                    else
                        state_next = CALC;
                end
            end
            CALC:    if (counter == CW'(1)) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    // W divides park the 32-bit dividend at the top of the quotient half so 32 shifts consume it.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            mul_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            counter   <= '0;
            acc       <= '0;
            sh        <= '0;
            opb       <= '0;
            resp_data <= '0;
        end else if (accept) begin
            op_q      <= req_op;
            mul_q     <= d_mul;
            neg_res_q <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
            counter   <= n_iter;
            opb       <= abs_b;
            if (d_mul) begin
`ifdef MDU_FAST_MUL_EN
                acc <= fast_prod;
`else
                acc <= '0;
`endif
                sh  <= {{XLEN{1'b0}}, abs_a};
            end else begin
                acc <= {{XLEN{1'b0}}, d_w ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a};
                sh  <= '0;
            end
            if (d_rsv || fast_div)
                resp_data <= fast_data;
        end else if (state == CALC) begin
            counter <= counter - CW'(1);
            if (mul_q) begin
                if (opb[0])
                    acc <= mul_sum;
                sh  <= sh << 1;
                opb <= opb >> 1;
            end else if (diff[XLEN]) begin
                acc <= {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc <= {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else if (state == FIXUP) begin
            resp_data <= fix_data;
        end
    end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Scoreboard bench for mdu_seq_ctrl: directed RV64M vectors, latency, back-pressure, flush and reset.
module tb_mdu_seq_ctrl;

    localparam int XLEN = 64;
    localparam int OPW  = 4;
`ifdef MDU_FAST_MUL_EN
    localparam int ML64 = 2;
    localparam int ML32 = 2;
`else
    localparam int ML64 = 66;
    localparam int ML32 = 34;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [OPW-1:0]  req_op = '0;
    logic [XLEN-1:0] req_op1 = '0;
    logic [XLEN-1:0] req_op2 = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [XLEN-1:0] resp_data;
    logic            busy;

    mdu_seq_ctrl #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] data;
        int              lat;
        int              acc_cyc;
        string           name;
    } exp_t;

    exp_t exp_q[$];
    int   num_checks = 0;
    int   num_errors = 0;
    logic inflight = 1'b0;
    logic seen_valid = 1'b0;

    task automatic checkOutput(input string name, input logic [XLEN-1:0] actual, input logic [XLEN-1:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: actual 0x%016h required 0x%016h", name, actual, expected);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: actual %b required %b", name, actual, expected);
        end
    endtask

    // Monitor: an accepted op keeps busy high until its handshake; flush or reset discards it.
    always @(negedge clk) begin
        if (rst) begin
            if (inflight && exp_q.size() > 0) void'(exp_q.pop_front());
            inflight   = 1'b0;
            seen_valid = 1'b0;
        end else begin
            checkFlag("busy", busy, inflight);
            if (flush) begin
                if (inflight && exp_q.size() > 0) void'(exp_q.pop_front());
                inflight   = 1'b0;
                seen_valid = 1'b0;
            end else begin
                if (resp_valid) begin
                    checkFlag("resp expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        if (!seen_valid) begin
                            checkOutput({exp_q[0].name, " latency"}, 64'(cyc - exp_q[0].acc_cyc), 64'(exp_q[0].lat));
                            seen_valid = 1'b1;
                        end
                        checkOutput({exp_q[0].name, " data"}, resp_data, exp_q[0].data);
                        if (resp_ready) begin
                            void'(exp_q.pop_front());
                            seen_valid = 1'b0;
                            inflight   = 1'b0;
                        end
                    end
                end
                if (req_valid && req_ready) inflight = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input string name, input logic [OPW-1:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [XLEN-1:0] expv, input int lat);
        exp_t e;
        logic accepted;
        accepted = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_op1   = a;
        req_op2   = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                accepted  = 1'b1;
                e.data    = expv;
                e.lat     = lat;
                e.acc_cyc = cyc;
                e.name    = name;
                exp_q.push_back(e);
                break;
            end
            @(posedge clk); #1;
        end
        checkFlag({name, " accept"}, accepted, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_op1   = ~a;
        req_op2   = b ^ 64'h5A5A_5A5A_5A5A_5A5A;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        checkOutput({name, " drain"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic runOp(input string name, input logic [OPW-1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] expv, input int lat);
        applyStimulus(name, op, a, b, expv, lat);
        waitDrain(name);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic got;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkFlag("reset req_ready", req_ready, 1'b0);
        checkFlag("reset resp_valid", resp_valid, 1'b0);
        checkFlag("reset busy", busy, 1'b0);
        checkOutput("reset resp_data", resp_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkFlag("idle req_ready", req_ready, 1'b1);

        runOp("MUL",     4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, ML64);
        runOp("MULH",    4'd1,  64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, ML64);
        runOp("MULHSU",  4'd2,  64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h2000_0000_0000_0000, ML64);
        runOp("MULW",    4'd4,  64'hDEAD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, ML32);
        runOp("DIV",     4'd5,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
        runOp("REM",     4'd7,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        runOp("REM pos", 4'd7,  64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 66);
        runOp("DIVU",    4'd6,  64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 66);
        runOp("DIVUW",   4'd10, 64'h0000_0000_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 34);
        runOp("REMUW",   4'd12, 64'hFFFF_FFFF_0000_000B, 64'hABCD_0000_0000_0003, 64'd2, 34);
        runOp("REMW",    4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        runOp("REMW ovf",  4'd11, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        runOp("DIV ovf",   4'd5,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        runOp("DIVU div0", 4'd6,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        runOp("REMU div0", 4'd8,  64'd5, 64'd0, 64'd5, 1);
        runOp("REMW div0", 4'd11, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0005, 1);
        runOp("DIVW div0", 4'd9,  64'd9, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        runOp("reserved",  4'd13, 64'd123, 64'd456, 64'd0, 1);

        resp_ready = 1'b0;
        applyStimulus("DIVW bp", 4'd9, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkFlag("bp resp_valid", got, 1'b1);
        repeat (10) begin
            @(negedge clk);
            checkOutput("bp resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFD);
            checkFlag("bp req_ready", req_ready, 1'b0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkFlag("bp release req_ready", req_ready, 1'b1);
        checkFlag("bp release resp_valid", resp_valid, 1'b0);
        waitDrain("DIVW bp");

        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 4'd6;
        flush     = 1'b1;
        @(negedge clk);
        checkFlag("flush blocks req_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        checkFlag("flush blocks accept", busy, 1'b0);

        applyStimulus("DIV flushed", 4'd5, 64'd1000, 64'd7, 64'd0, 66);
        repeat (19) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        checkFlag("post-flush req_ready", req_ready, 1'b1);
        checkFlag("post-flush resp_valid", resp_valid, 1'b0);
        runOp("MULHU", 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, ML64);

        applyStimulus("DIV reset", 4'd5, 64'd1000, 64'd7, 64'd0, 66);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkFlag("mid reset req_ready", req_ready, 1'b0);
        checkFlag("mid reset resp_valid", resp_valid, 1'b0);
        checkFlag("mid reset busy", busy, 1'b0);
        checkOutput("mid reset resp_data", resp_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkFlag("post-reset req_ready", req_ready, 1'b1);
        runOp("DIVU recover", 4'd6, 64'd100, 64'd7, 64'd14, 66);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Multi-cycle multiply/divide sequencer beside the EXU. Replaces the single-cycle mul/div/rem datapath.
- Accepts one RV64M operation at a time from the EXU over a valid/ready handshake.
- Runs an iterative shift-add multiplier or a restoring divider, one bit per cycle.
- Returns the sign-fixed, W-extended result over a valid/ready handshake. Drives busy so the pipeline controller can stall issue.

Parameters:
- XLEN, 64, operand/result width.
- OPW, 4, width of op code.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush; aborts any in-flight op.
- req_valid  in  1  EXU presents an op.
- req_ready  out  1  controller can accept an op.
- req_op  in  OPW  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5 DIV, 6 DIVU, 7 REM, 8 REMU, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW; 13-15 reserved.
- req_op1  in  XLEN  rs1 value.
- req_op2  in  XLEN  rs2 value.
- resp_valid  out  1  result available.
- resp_ready  in  1  WBU/pipeline accepts result.
- resp_data  out  XLEN  result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; resp_valid=0; resp_data=0; busy=0; counter=0.
  - req_ready is forced to 0 while rst=1.
- States: IDLE, CALC, FIXUP, DONE.
- req_ready:
  - 1 only in IDLE with rst=0 and flush=0.
  - Accept = req_valid & req_ready.
  - Operands and op are latched on accept; later changes on req_* are ignored.
- Operand preparation on accept:
  - Signed ops take absolute values and record result sign. Signs: MULH both operands; MULHSU op1 only; DIV/REM/DIVW/REMW both.
  - W ops use bits [31:0], sign- or zero-extended per op.
  - Iteration count N=32 for W ops, else 64.
- Fast path (divide ops only, decided on accept, IDLE->DONE directly, resp_valid next cycle):
  - Divisor==0: quotient=all ones (W: 0xFFFFFFFF sign-extended); remainder=dividend (W: sign-extended low 32).
  - Signed overflow (dividend = most negative for width, divisor = -1): quotient=dividend; remainder=0.
- IDLE->CALC on accept otherwise; counter loads N.
- CALC, one step per cycle, counter decrements; ->FIXUP when counter reaches 1 at the clock edge, i.e. exactly N cycles in CALC.
  - Multiply: 128-bit accumulator; add shifted multiplicand when current multiplier bit=1.
  - Divide: restoring shift-subtract on {rem, quot}.
- FIXUP, one cycle:
  - Apply two's-complement negation per recorded sign. Remainder takes the dividend's sign.
  - Select product/quotient/remainder and the low or high half.
  - W ops: sign-extend bit 31 of the 32-bit result.
  - Register resp_data; ->DONE.
- DONE:
  - resp_valid=1; resp_data held stable until resp_ready=1.
  - On resp_valid & resp_ready: ->IDLE and resp_valid=0 at the next edge.
  - New op not accepted in the same cycle.
- Latency, normal path: accept at cycle 0 -> resp_valid at cycle N+2 (66 for 64-bit, 34 for W).
- flush=1 in any state:
  - Next state IDLE, resp_valid=0, no response issued. Takes priority over resp_ready and accept.
  - A flush in the same cycle as req_valid blocks acceptance (req_ready=0).
- Reserved op codes: accepted, go IDLE->DONE, resp_data=0.
- rst has priority over flush; reset mid-operation discards all state.

Optional Feature:
- MDU_FAST_MUL_EN.
- Defined:
  - Multiply ops (0-4) use a single-cycle combinational 128-bit signed/unsigned product.
  - Path: accept -> FIXUP next cycle -> DONE; resp_valid at cycle 2 after accept.
  - Divide unchanged.
- Undefined: multiply iterates N cycles as in CALC. The combinational multiplier is not synthesised.

Test Plan:
- MUL op1=7, op2=-3 (0xFFFFFFFFFFFFFFFD), resp_ready=1 -> resp_data=0xFFFFFFFFFFFFFFEB; resp_valid at cycle 66 (cycle 2 with MDU_FAST_MUL_EN); busy high throughout.
- DIV op1=-20, op2=3 -> 0xFFFFFFFFFFFFFFFA (-6). REM same operands -> 0xFFFFFFFFFFFFFFFE (-2). Both at cycle 66.
- DIVUW op1=0x00000000_80000000, op2=2 -> 0x0000000040000000 at cycle 34. REMW op1=0x80000000, op2=-1 -> 0 via fast path at cycle 1.
- DIVU op2=0 with op1=5 -> 0xFFFFFFFFFFFFFFFF at cycle 1. REMU same operands -> 5.
- Back-pressure: hold resp_ready=0 for 10 cycles after resp_valid -> resp_data stable, req_ready=0. Then resp_ready=1 -> IDLE next cycle, req_ready=1.
- Flush at cycle 20 of a DIV -> no resp_valid ever for that op; req_ready=1 next cycle; new MULHU 0xFFFFFFFFFFFFFFFF*2 -> 0x0000000000000001. Repeat with rst at cycle 20 -> all outputs reset values.
